// File: rtl/sha512_stream_ctrl.sv
// Stream front-end for sha512_block: packs 64-bit beats into 1024-bit blocks,
// applies SHA-512 padding and length, chains H and hands out the final digest.
//
// state  | meaning
// S_FILL | accepting message beats into the block buffer
// S_PAD  | one cycle inserting the 0x80 marker, zero fill and (maybe) length
// S_RUN  | block handed to sha512_block, waiting out the round timer
// S_DONE | digest presented, waiting for digest_ready
module sha512_stream_ctrl #(
  parameter int ROUNDS = 80,
  parameter int LEN_W  = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   s_data,
  input  logic [3:0]    s_nbytes,
  input  logic          s_last,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [1023:0] blk_M,
  output logic [511:0]  blk_H,
  output logic          blk_start,
  input  logic [511:0]  blk_H_out,
  output logic [511:0]  digest,
  output logic          digest_valid,
  input  logic          digest_ready
);

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam int TW = $clog2(ROUNDS + 1) + 1;

  typedef enum logic [1:0] {S_FILL, S_PAD, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [63:0]      w_q [16];
  logic [63:0]      w_d [16];
  logic [3:0]       idx_q, idx_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       pos_q, pos_d;
  logic             final_q, final_d;
  logic             extra_q, extra_d;
  logic             pend_q, pend_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [511:0]     h_q, h_d;
  logic [511:0]     dig_q, dig_d;

  logic             accept;
  logic [3:0]       nb;
  logic [63:0]      beat_keep;
  logic [63:0]      pad_keep;
  logic [63:0]      marker;
  logic [4:0]       pw;
  logic [2:0]       pb;
  logic [127:0]     len_bits;

  assign s_ready      = rst & (state_q == S_FILL);
  assign accept       = s_valid & s_ready;
  assign nb           = (s_nbytes > 4'd8) ? 4'd8 : s_nbytes;
  assign beat_keep    = ~({64{1'b1}} >> {nb, 3'b000});
  // pos_q is the block byte offset of the 0x80 marker; 128 means "next block"
  assign pw           = pos_q[7:3];
  assign pb           = pos_q[2:0];
  assign pad_keep     = ~({64{1'b1}} >> {pb, 3'b000});
  assign marker       = 64'h80 << {3'd7 - pb, 3'b000};
  assign len_bits     = 128'(cnt_q) << 3;
  assign blk_H        = h_q;
  assign blk_start    = (state_q == S_RUN) & pend_q;
  assign digest       = dig_q;
  assign digest_valid = (state_q == S_DONE);

  for (genvar g = 0; g < 16; g++) begin : g_blk
    assign blk_M[1023-64*g -: 64] = w_q[g];
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    final_d = final_q;
    extra_d = extra_q;
    pend_d  = pend_q;
    tmr_d   = tmr_q;
    h_d     = h_q;
    dig_d   = dig_q;
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          w_d[idx_q] = s_data & beat_keep;
          idx_d      = idx_q + 4'd1;
          cnt_d      = cnt_q + LEN_W'(nb);
          if (s_last) begin
            pos_d   = 8'({idx_q, 3'b000}) + 8'(nb);
            state_d = S_PAD;
          end else if (idx_q == 4'd15) begin
            final_d = 1'b0;
            extra_d = 1'b0;
            pend_d  = 1'b1;
            state_d = S_RUN;
          end
        end
      end
      S_PAD: begin
        for (int w = 0; w < 16; w++) begin
          if (5'(w) == pw) begin
            w_d[w] = (w_q[w] & pad_keep) | marker;
          end else if (5'(w) > pw) begin
            w_d[w] = 64'h0;
          end
        end
        final_d = (pos_q <= 8'd111);
        extra_d = (pos_q > 8'd111);
        if (pos_q <= 8'd111) begin
          w_d[14] = len_bits[127:64];
          w_d[15] = len_bits[63:0];
        end
        pend_d  = 1'b1;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (pend_q) begin
          pend_d = 1'b0;
          tmr_d  = TW'(ROUNDS);
        end else if (tmr_q != '0) begin
          tmr_d = tmr_q - TW'(1);
        end else begin
          h_d   = blk_H_out;
          idx_d = 4'd0;
          if (final_q) begin
            dig_d   = blk_H_out;
            state_d = S_DONE;
          end else if (extra_q) begin
            // length-only block; carries the marker if the message ended on a block boundary
            for (int w = 0; w < 16; w++) w_d[w] = 64'h0;
            w_d[0]  = pos_q[7] ? 64'h8000_0000_0000_0000 : 64'h0;
            w_d[14] = len_bits[127:64];
            w_d[15] = len_bits[63:0];
            final_d = 1'b1;
            extra_d = 1'b0;
            pend_d  = 1'b1;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      S_DONE: begin
        if (digest_ready) begin
          h_d     = IV;
          cnt_d   = '0;
          state_d = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FILL;
      for (int i = 0; i < 16; i++) w_q[i] <= 64'h0;
      idx_q   <= 4'd0;
      cnt_q   <= '0;
      pos_q   <= 8'd0;
      final_q <= 1'b0;
      extra_q <= 1'b0;
      pend_q  <= 1'b0;
      tmr_q   <= '0;
      h_q     <= IV;
      dig_q   <= 512'h0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      final_q <= final_d;
      extra_q <= extra_d;
      pend_q  <= pend_d;
      tmr_q   <= tmr_d;
      h_q     <= h_d;
      dig_q   <= dig_d;
    end
  end

endmodule

// File: tb/tb_sha512_stream_ctrl.sv
// Bench for sha512_stream_ctrl: behavioural sha512_block stands in for the core,
// expected digests go through a scoreboard queue.
module tb_sha512_stream_ctrl;
  localparam int ROUNDS = 80;

  localparam logic [511:0] IV = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};

  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  localparam logic [511:0] D_EMPTY = 512'hcf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e;
  localparam logic [511:0] D_ABC   = 512'hddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f;
  localparam logic [511:0] D_112   = 512'h8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   s_data;
  logic [3:0]    s_nbytes;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [1023:0] blk_M;
  logic [511:0]  blk_H;
  logic          blk_start;
  logic [511:0]  blk_H_out = '0;
  logic [511:0]  digest;
  logic          digest_valid;
  logic          digest_ready;

  int            checks = 0;
  int            errors = 0;
  int            starts = 0;
  bit            rst_hit = 1'b0;
  logic [1023:0] m_log [$];
  logic [511:0]  exp_q [$];
  string         s112 = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";

  sha512_stream_ctrl #(.ROUNDS(ROUNDS), .LEN_W(64)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_nbytes(s_nbytes), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .blk_M(blk_M), .blk_H(blk_H),
    .blk_start(blk_start), .blk_H_out(blk_H_out), .digest(digest),
    .digest_valid(digest_valid), .digest_ready(digest_ready));

  always #5 clk = ~clk;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [511:0] compress(input logic [511:0] hin, input logic [1023:0] m);
    logic [63:0] w [80];
    logic [63:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = m[1023-64*i -: 64];
    for (int i = 16; i < 80; i++)
      w[i] = (rotr(w[i-2], 19) ^ rotr(w[i-2], 61) ^ (w[i-2] >> 6)) + w[i-7]
           + (rotr(w[i-15], 1) ^ rotr(w[i-15], 8) ^ (w[i-15] >> 7)) + w[i-16];
    {a, b, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 80; i++) begin
      t1 = hh + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[511:448] + a, hin[447:384] + b, hin[383:320] + c, hin[319:256] + d,
            hin[255:192] + e, hin[191:128] + f, hin[127:64] + g, hin[63:0] + hh};
  endfunction

  function automatic logic [511:0] sha512_ref(input logic [7:0] msg [$]);
    logic [7:0]    p [$];
    logic [127:0]  lbits;
    logic [1023:0] blk;
    logic [511:0]  h;
    p = msg;
    p.push_back(8'h80);
    while (p.size() % 128 != 112) p.push_back(8'h00);
    lbits = 128'(msg.size()) * 128'd8;
    for (int i = 15; i >= 0; i--) p.push_back(lbits[8*i +: 8]);
    h = IV;
    for (int bk = 0; bk < p.size() / 128; bk++) begin
      for (int j = 0; j < 128; j++) blk[1023-8*j -: 8] = p[bk*128+j];
      h = compress(h, blk);
    end
    return h;
  endfunction

  // sha512_block stand-in: result only appears on the capture cycle, garbage otherwise
  logic [1023:0] mdl_m;
  logic [511:0]  mdl_h, mdl_res;
  bit            mdl_ok;
  always @(negedge rst) rst_hit = 1'b1;
  always begin
    @(negedge clk);
    if (rst === 1'b1 && blk_start === 1'b1) begin
      mdl_m = blk_M; mdl_h = blk_H; mdl_res = compress(mdl_h, mdl_m);
      starts++; m_log.push_back(mdl_m); rst_hit = 1'b0; mdl_ok = 1'b1;
      blk_H_out = ~mdl_res;
      for (int i = 0; i < ROUNDS + 1; i++) begin
        @(negedge clk);
        if (rst_hit) break;
        if (blk_M !== mdl_m || blk_H !== mdl_h || blk_start !== 1'b0) mdl_ok = 1'b0;
      end
      if (!rst_hit) begin
        checks++;
        if (!mdl_ok) begin
          errors++;
          $display("FAIL blk_hold: block %0d inputs moved or blk_start not a single pulse, required held", starts);
        end
        blk_H_out = mdl_res;
        @(posedge clk); #1;
        blk_H_out = ~mdl_res;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_msg(input logic [7:0] msg [$]);
    int n, beats, nb, g;
    logic [63:0] d;
    n = msg.size();
    beats = (n == 0) ? 1 : (n + 7) / 8;
    for (int b = 0; b < beats; b++) begin
      nb = n - 8 * b;
      if (nb > 8) nb = 8;
      d = 64'hA5C3_5A3C_9669_F00F;
      for (int k = 0; k < nb; k++) d[63-8*k -: 8] = msg[8*b+k];
      @(negedge clk);
      s_data = d; s_nbytes = 4'(nb); s_last = (b == beats - 1); s_valid = 1'b1;
      g = 0;
      while (s_ready !== 1'b1 && g < 5000) begin @(negedge clk); g++; end
      if (g >= 5000) begin
        checks++; errors++;
        $display("FAIL send_timeout: beat %0d never accepted, s_ready=%b required 1", b, s_ready);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
    end
  endtask

  task automatic wait_dv(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (digest_valid === 1'b1) begin ok = 1'b1; break; end
    end
  endtask

  task automatic ack;
    digest_ready = 1'b1;
    @(posedge clk); #1;
    digest_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
    checks++; if (blk_start !== 1'b0) begin errors++; $display("FAIL rst_blk_start: got %b want 0", blk_start); end
    checks++; if (digest_valid !== 1'b0) begin errors++; $display("FAIL rst_digest_valid: got %b want 0", digest_valid); end
    checks++; if (digest !== 512'h0) begin errors++; $display("FAIL rst_digest: got %h want 0", digest); end
    checks++; if (blk_H !== IV) begin errors++; $display("FAIL rst_blk_H: got %h want %h", blk_H, IV); end
    checks++; if (blk_M !== 1024'h0) begin errors++; $display("FAIL rst_blk_M: got nonzero want 0"); end
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_release_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_empty;
    logic [7:0] msg [$];
    bit ok; int s0; logic [511:0] e;
    exp_q.push_back(D_EMPTY);
    s0 = starts;
    send_msg(msg);
    wait_dv(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL empty_timeout: digest_valid=%b want 1", digest_valid); end
    else begin
      e = exp_q.pop_front();
      if (digest !== e) begin errors++; $display("FAIL empty_digest: got %h want %h", digest, e); end
    end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL empty_starts: got %0d want 1", starts - s0); end
    ack();
  endtask

  task automatic test_abc;
    logic [7:0] msg [$];
    bit ok; logic [511:0] e;
    msg = '{8'h61, 8'h62, 8'h63};
    m_log.delete();
    exp_q.push_back(D_ABC);
    send_msg(msg);
    wait_dv(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL abc_timeout: digest_valid=%b want 1", digest_valid); end
    else begin
      e = exp_q.pop_front();
      if (digest !== e) begin errors++; $display("FAIL abc_digest: got %h want %h", digest, e); end
    end
    checks++;
    if (m_log.size() != 1) begin errors++; $display("FAIL abc_blocks: got %0d want 1", m_log.size()); end
    else begin
      if (m_log[0][1023:960] !== 64'h6162638000000000) begin
        errors++; $display("FAIL abc_word0: got %h want 6162638000000000", m_log[0][1023:960]);
      end
      checks++;
      if (m_log[0][63:0] !== 64'h18) begin errors++; $display("FAIL abc_word15: got %h want 18", m_log[0][63:0]); end
    end
    ack();
  endtask

  task automatic test_two_block;
    logic [7:0] msg [$];
    bit ok; int s0; logic [511:0] e;
    for (int i = 0; i < 112; i++) msg.push_back(s112[i]);
    m_log.delete();
    exp_q.push_back(D_112);
    s0 = starts;
    send_msg(msg);
    wait_dv(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b112_timeout: digest_valid=%b want 1", digest_valid); end
    else begin
      e = exp_q.pop_front();
      if (digest !== e) begin errors++; $display("FAIL b112_digest: got %h want %h", digest, e); end
    end
    checks++; if (starts - s0 !== 2) begin errors++; $display("FAIL b112_starts: got %0d want 2", starts - s0); end
    checks++;
    if (m_log.size() != 2) begin errors++; $display("FAIL b112_blocks: got %0d want 2", m_log.size()); end
    else begin
      if (m_log[0][1023-8*112 -: 8] !== 8'h80) begin
        errors++; $display("FAIL b112_marker: byte112 got %h want 80", m_log[0][1023-8*112 -: 8]);
      end
      checks++;
      if (m_log[1] !== {896'h0, 128'h380}) begin
        errors++; $display("FAIL b112_lenblock: word14 %h word15 %h want 0 and 380", m_log[1][127:64], m_log[1][63:0]);
      end
    end
    ack();
  endtask

  task automatic test_boundary_111;
    logic [7:0] msg [$];
    bit ok; int s0; logic [511:0] e;
    for (int i = 0; i < 111; i++) msg.push_back(s112[i]);
    m_log.delete();
    exp_q.push_back(sha512_ref(msg));
    s0 = starts;
    send_msg(msg);
    wait_dv(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b111_timeout: digest_valid=%b want 1", digest_valid); end
    else begin
      e = exp_q.pop_front();
      if (digest !== e) begin errors++; $display("FAIL b111_digest: got %h want %h", digest, e); end
    end
    checks++; if (starts - s0 !== 1) begin errors++; $display("FAIL b111_starts: got %0d want 1", starts - s0); end
    checks++;
    if (m_log.size() != 1) begin errors++; $display("FAIL b111_blocks: got %0d want 1", m_log.size()); end
    else if (m_log[0][1023-8*111 -: 8] !== 8'h80 || m_log[0][127:0] !== 128'h378) begin
      errors++; $display("FAIL b111_pad: byte111 %h len %h want 80 and 378", m_log[0][1023-8*111 -: 8], m_log[0][127:0]);
    end
    ack();
  endtask

  task automatic test_hold_and_back_to_back;
    logic [7:0] msg [$];
    bit ok, stable; logic [511:0] d0, e;
    msg = '{8'h61, 8'h62, 8'h63};
    exp_q.push_back(D_ABC);
    send_msg(msg);
    wait_dv(ok);
    d0 = digest;
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_timeout: digest_valid=%b want 1", digest_valid); end
    else begin
      e = exp_q.pop_front();
      if (d0 !== e) begin errors++; $display("FAIL hold_digest: got %h want %h", d0, e); end
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (digest !== d0 || digest_valid !== 1'b1 || s_ready !== 1'b0) stable = 1'b0;
    end
    checks++; if (!stable) begin errors++; $display("FAIL hold_stable: digest/valid/s_ready moved while stalled, want held"); end
    digest_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (s_ready !== 1'b1 || digest_valid !== 1'b0) begin
      errors++; $display("FAIL hold_release: s_ready=%b digest_valid=%b want 1 and 0", s_ready, digest_valid);
    end
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(D_ABC);
      send_msg(msg);
      wait_dv(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout: run %0d digest_valid=%b want 1", r, digest_valid); end
      else begin
        e = exp_q.pop_front();
        if (digest !== e) begin errors++; $display("FAIL b2b_digest: run %0d got %h want %h", r, digest, e); end
      end
    end
    @(posedge clk); #1;
    digest_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    logic [7:0] msg [$];
    bit ok; int s0, g; logic [511:0] e;
    msg = '{8'h61, 8'h62, 8'h63};
    s0 = starts;
    send_msg(msg);
    g = 0;
    while (starts == s0 && g < 200) begin @(negedge clk); g++; end
    checks++; if (starts == s0) begin errors++; $display("FAIL midrst_start: blk_start count got %0d want %0d", starts, s0 + 1); end
    repeat (30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (blk_start !== 1'b0 || s_ready !== 1'b0 || digest_valid !== 1'b0 || blk_H !== IV || blk_M !== 1024'h0) begin
      errors++; $display("FAIL midrst_async: blk_start=%b s_ready=%b digest_valid=%b want 0 0 0 with IV and zero block",
                         blk_start, s_ready, digest_valid);
    end
    @(negedge clk); #2 rst = 1'b1;
    exp_q.push_back(D_ABC);
    send_msg(msg);
    wait_dv(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: digest_valid=%b want 1", digest_valid); end
    else begin
      e = exp_q.pop_front();
      if (digest !== e) begin errors++; $display("FAIL midrst_digest: got %h want %h", digest, e); end
    end
    ack();
  endtask

  initial begin
    rst = 1'b0; s_data = '0; s_nbytes = '0; s_last = 1'b0; s_valid = 1'b0; digest_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_empty();
    test_abc();
    test_two_block();
    test_boundary_111();
    test_hold_and_back_to_back();
    test_reset_mid_run();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d entries want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha512_stream_ctrl.md
Name: sha512_stream_ctrl

Overview:
Upstream sequencer for sha512_block. It accepts a big-endian byte message as a stream of 64-bit beats and assembles 1024-bit blocks. It applies SHA-512 padding and the 128-bit length field, drives sha512_block one block at a time, chains the hash value, and presents the final 512-bit digest through a valid/ready handshake. One message is in flight at a time; the block is not pipelined.

Parameters:
ROUNDS, 80, cycles sha512_block needs after its load cycle; the digest is captured ROUNDS+1 cycles after blk_start.
LEN_W, 64, width of the internal byte counter; bits of the 128-bit length field above LEN_W+3 are zero.

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
s_data  in  64  message beat; first byte in [63:56]
s_nbytes  in  4  valid bytes in beat, left-aligned; must be 8 unless s_last; 0..8 legal on the last beat
s_last  in  1  final beat of the message
s_valid  in  1  beat offered
s_ready  out  1  beat accepted when s_valid & s_ready
blk_M  out  1024  block to sha512_block M_in; word 0 in [1023:960]
blk_H  out  512  chaining value to sha512_block H_in
blk_start  out  1  one-cycle pulse to sha512_block input_valid
blk_H_out  in  512  sha512_block H_out
digest  out  512  final hash
digest_valid  out  1  digest available
digest_ready  in  1  digest consumed when digest_valid & digest_ready

Behaviour:
- Reset (rst low, asynchronous): state FILL, word index 0, byte count 0, blk_M 0, blk_H = SHA-512 IV, blk_start 0, digest 0, digest_valid 0. s_ready is 0 while rst is low.
- FILL state:
  - s_ready=1.
  - Each accepted beat is written to word[idx]; idx increments and byte count += s_nbytes.
  - On an accepted non-last beat that fills word 15, go to RUN with a pending flag, then pulse blk_start.
  - On an accepted last beat, go to PAD.
- PAD state (s_ready=0):
  - Byte 0x80 goes immediately after the last message byte, in the same word or the next word if that word is full.
  - Remaining bytes up to word 13 are zero.
  - If the 0x80 byte lands at byte offset ≤111 of the block: words 14..15 = {zero, byte_count<<3} as 128 bits, mark the block final, go to RUN.
  - Otherwise zero the rest of the block and run it non-final. The next block is all zeros plus the length in words 14..15 and is final.
- RUN state:
  - blk_start is high for exactly one cycle t; blk_M and blk_H are held stable from cycle t through t+ROUNDS+1.
  - At the end of cycle t+ROUNDS+1, capture blk_H_out into blk_H.
  - Non-final block: idx=0, go to FILL (or to the length-only block).
  - Final block: digest <= blk_H_out, go to DONE.
- DONE state:
  - digest_valid=1, held stable until digest_ready.
  - On handshake: digest_valid 0, blk_H <= IV, byte count 0, go to FILL.
  - Earliest s_ready is the cycle after the handshake.
- Byte count wraps modulo 2^LEN_W silently.
- s_valid is ignored whenever s_ready=0.
- An s_nbytes value other than 8 on a non-last beat is a protocol violation; the result is undefined but must not hang the FSM.
- Reset asserted mid-RUN or mid-DONE aborts the message; the next message after reset release starts from IV.
- Block cadence: 16 input cycles + 1 pad cycle + ROUNDS+2 compute cycles. Throughput is unspecified beyond "no lost beats".

Test Plan:
- Empty message (single beat, s_last=1, s_nbytes=0) -> one blk_start; digest = cf83e1357eefb8bdf1542850d66d8007d620e4050b5715dc83f4a921d36ce9ce47d0d13c5d85f2b0ff8318d2877eec2f63b931bd47417a81a538327af927da3e.
- "abc" (s_data=0x6162630000000000, s_nbytes=3, s_last) -> blk_M word0=0x6162638000000000, word15=0x18; digest = ddaf35a193617abacc417349ae20413112e6fa4e89a97ea20a9eeee64b55d39a2192992a274fc1a836ba3c23a3feebbd454d4423643ce80e2a9ac94fa54ca49f.
- 112-byte message "abcdefghbcdefghi...nopqrstu" as 14 beats -> two blk_start pulses, second block all-zero except length 0x380; digest = 8e959b75dae313da8cf4f72814fc143f8f7779c6eb9f7fa17299aeadb6889018501d289e4900f7e4331b99dec4b5433ac7d329eeb6dd26545e96e55b874be909.
- 111-byte vs 112-byte boundary -> exactly 1 vs 2 blk_start pulses; 0x80 at byte 111 vs byte 112.
- Hold digest_ready=0 for 20 cycles after digest_valid -> digest stable, s_ready=0. Then back-to-back "abc" twice with digest_ready=1 -> both digests equal the "abc" value, proving the IV is restored.
- Drop rst for one cycle 30 cycles into RUN -> outputs reset immediately. A subsequent "abc" yields the correct digest.
